// File: rtl/flappy_pkg.sv
// Shared constants and types for the pipe feeder and its LFSR.
package flappy_pkg;

   localparam int unsigned HEIGHT_W = 5;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned PP_W     = 8;
   localparam int unsigned LFSR_W   = 16;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   localparam logic [1:0] COL_EMPTY = 2'b00;
   localparam logic [1:0] COL_EDGE  = 2'b11;
   localparam logic [1:0] COL_BODY  = 2'b01;

   typedef enum logic [1:0] {IDLE, GAP, PIPE} feeder_state_t;

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR: synchronous load of seed, one shift per adv pulse.
module lfsr16_galois
   import flappy_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_VAL = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              adv,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= RST_VAL;
      else if (load)
         value <= seed;
      else if (adv)
         value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
   end

endmodule

// File: rtl/pipe_feeder.sv
// Obstacle column generator: emits empty/pipe column codes per scroll step with LFSR gaps.
// Optional spacing ramp enabled by defining PIPE_FEEDER_RAMP_EN.
module pipe_feeder
   import flappy_pkg::*;
#(
   parameter int unsigned       SPACING = 8,
   parameter int unsigned       PIPE_W  = 2,
   parameter int unsigned       GAP_H   = 6,
   parameter int unsigned       H_MAX   = 20,
   parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                step,
   output logic [1:0]          col,
   output logic                col_valid,
   output logic [HEIGHT_W-1:0] gap_lo,
   output logic [HEIGHT_W-1:0] gap_hi,
   output logic [PP_W-1:0]     pipes_passed
);

   localparam int unsigned LO_MAX = H_MAX - GAP_H;

   feeder_state_t       state, state_nxt;
   logic [CNT_W-1:0]    gcnt, gcnt_nxt, wcnt, wcnt_nxt;
   logic [1:0]          col_nxt;
   logic                col_valid_nxt;
   logic [HEIGHT_W-1:0] gap_lo_nxt, gap_hi_nxt, cand;
   logic [PP_W-1:0]     pp_nxt;
   logic                load, draw;
   logic [LFSR_W-1:0]   lfsr;
   logic                unused_lfsr;

`ifdef PIPE_FEEDER_RAMP_EN
   logic [CNT_W-1:0]    spacing_cur, spacing_nxt;
`else
   logic [CNT_W-1:0]    spacing_cur;
   assign spacing_cur = CNT_W'(SPACING);
`endif

   lfsr16_galois #(.RST_VAL(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .seed  (SEED),
      .adv   (draw),
      .value (lfsr)
   );

   assign unused_lfsr = ^lfsr[LFSR_W-1:HEIGHT_W];

   // Fold the 5-bit LFSR slice into 1..LO_MAX
   always_comb begin
      cand = lfsr[HEIGHT_W-1:0];
      if (cand > HEIGHT_W'(LO_MAX))
         cand = cand - HEIGHT_W'(LO_MAX + 1);
      if (cand == '0)
         cand = HEIGHT_W'(1);
      else if (cand > HEIGHT_W'(LO_MAX))
         cand = HEIGHT_W'(LO_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         col          <= COL_EMPTY;
         col_valid    <= 1'b0;
         gap_lo       <= '0;
         gap_hi       <= '1;
         pipes_passed <= '0;
         gcnt         <= '0;
         wcnt         <= '0;
`ifdef PIPE_FEEDER_RAMP_EN
         spacing_cur  <= CNT_W'(SPACING);
`endif
      end else begin
         state        <= state_nxt;
         col          <= col_nxt;
         col_valid    <= col_valid_nxt;
         gap_lo       <= gap_lo_nxt;
         gap_hi       <= gap_hi_nxt;
         pipes_passed <= pp_nxt;
         gcnt         <= gcnt_nxt;
         wcnt         <= wcnt_nxt;
`ifdef PIPE_FEEDER_RAMP_EN
         spacing_cur  <= spacing_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      col_nxt       = col;
      col_valid_nxt = 1'b0;
      gap_lo_nxt    = gap_lo;
      gap_hi_nxt    = gap_hi;
      pp_nxt        = pipes_passed;
      gcnt_nxt      = gcnt;
      wcnt_nxt      = wcnt;
      load          = 1'b0;
      draw          = 1'b0;
`ifdef PIPE_FEEDER_RAMP_EN
      spacing_nxt   = spacing_cur;
`endif
      case (state)
         IDLE: begin
            load       = 1'b1;
            col_nxt    = COL_EMPTY;
            pp_nxt     = '0;
            gap_lo_nxt = '0;
            gap_hi_nxt = '1;
`ifdef PIPE_FEEDER_RAMP_EN
            spacing_nxt = CNT_W'(SPACING);
`endif
            if (run) begin
               state_nxt = GAP;
               gcnt_nxt  = CNT_W'(SPACING);
            end
         end
         GAP: begin
            if (!run) begin
               state_nxt = IDLE;
            end else if (step) begin
               col_valid_nxt = 1'b1;
               col_nxt       = COL_EMPTY;
               gcnt_nxt      = gcnt - CNT_W'(1);
               if (gcnt == CNT_W'(1)) begin
                  state_nxt  = PIPE;
                  wcnt_nxt   = CNT_W'(PIPE_W);
                  draw       = 1'b1;
                  gap_lo_nxt = cand;
                  gap_hi_nxt = cand + HEIGHT_W'(GAP_H);
               end
            end
         end
         PIPE: begin
            if (!run) begin
               state_nxt = IDLE;
            end else if (step) begin
               col_valid_nxt = 1'b1;
               col_nxt       = (wcnt == CNT_W'(PIPE_W)) ? COL_EDGE : COL_BODY;
               wcnt_nxt      = wcnt - CNT_W'(1);
               if (wcnt == CNT_W'(1)) begin
                  state_nxt = GAP;
                  if (pipes_passed != '1)
                     pp_nxt = pipes_passed + PP_W'(1);
`ifdef PIPE_FEEDER_RAMP_EN
                  // Tighten spacing every fourth pipe; takes effect on this GAP entry
                  if ((pipes_passed != '1) && (pp_nxt[1:0] == 2'b00) &&
                      (spacing_cur > CNT_W'(3)))
                     spacing_nxt = spacing_cur - CNT_W'(1);
                  gcnt_nxt = spacing_nxt;
`else
                  gcnt_nxt = spacing_cur;
`endif
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pipe_feeder.sv
// Scoreboard bench for pipe_feeder; the model honours PIPE_FEEDER_RAMP_EN when defined.
module tb_pipe_feeder;

   localparam int SP0 = 8;
   localparam int PW  = 2;
   localparam int GH  = 6;
   localparam int LOM = 14;

   logic       clk = 1'b0;
   logic       reset, run, step;
   logic [1:0] col;
   logic       col_valid;
   logic [4:0] gap_lo, gap_hi;
   logic [7:0] pipes_passed;

   pipe_feeder dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .step         (step),
      .col          (col),
      .col_valid    (col_valid),
      .gap_lo       (gap_lo),
      .gap_hi       (gap_hi),
      .pipes_passed (pipes_passed)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] col;
      logic [4:0] lo;
      logic [4:0] hi;
      logic [7:0] pp;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: column index within the current pipe period
   bit [15:0] m_lfsr;
   int        m_idx, m_sp, m_pp, m_lo, m_hi, m_col;
   bit        m_active;

   function automatic void m_reload();
      m_lfsr = 16'hACE1;
      m_idx  = 0;
      m_sp   = SP0;
      m_pp   = 0;
      m_lo   = 0;
      m_hi   = 31;
   endfunction

   function automatic void m_draw();
      int c;
      c = int'(m_lfsr % 32);
      if (c > LOM) c = c - (LOM + 1);
      if (c < 1) c = 1;
      if (c > LOM) c = LOM;
      m_lo = c;
      m_hi = c + GH;
      if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 16'hB400;
      else                 m_lfsr = m_lfsr / 2;
   endfunction

   function automatic void m_step(input int now);
      exp_t e;
      bit   inc;
      if (m_idx < m_sp) begin
         m_col = 0;
         if (m_idx == m_sp - 1) m_draw();
      end else begin
         m_col = (m_idx == m_sp) ? 3 : 1;
      end
      m_idx++;
      if (m_idx == m_sp + PW) begin
         m_idx = 0;
         inc = (m_pp < 255);
         if (inc) m_pp++;
`ifdef PIPE_FEEDER_RAMP_EN
         if (inc && (m_pp % 4 == 0) && m_sp > 3) m_sp--;
`endif
      end
      e.cyc = now + 1;
      e.col = 2'(m_col);
      e.lo  = 5'(m_lo);
      e.hi  = 5'(m_hi);
      e.pp  = 8'(m_pp);
      q.push_back(e);
   endfunction

   // Monitor: every col_valid must match the oldest expectation on its cycle
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (col_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 32'(col_valid), 32'd0);
            end else begin
               e = q.pop_front();
               chk("latency", 32'(cyc), 32'(e.cyc));
               chk("column", {18'd0, col, gap_lo, gap_hi, pipes_passed},
                   {18'd0, e.col, e.lo, e.hi, e.pp});
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("missing_valid", 32'(col_valid), 32'd1);
            void'(q.pop_front());
         end
      end
   end

   task automatic cyc_step(input bit s);
      @(negedge clk);
      step = s;
      if (s && run && m_active) m_step(cyc);
   endtask

   task automatic chk_idle(input string name);
      chk(name, {13'd0, col, col_valid, gap_lo, gap_hi, pipes_passed},
          {13'd0, 2'b00, 1'b0, 5'd0, 5'd31, 8'd0});
   endtask

   task automatic drop_run();
      @(negedge clk);
      run = 1'b0;
      step = 1'($urandom_range(0, 1));
      m_active = 1'b0;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      chk_idle("idle_after_drop");
      run = 1'b1;
      m_reload();
      @(negedge clk);
      m_active = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      m_active = 1'b0;
      m_reload();
      repeat (3) @(negedge clk);
      chk_idle("reset_values");
      reset = 1'b0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      m_active = 1'b1;

      // First gap run with spaced steps
      for (int i = 0; i < 8; i++) begin
         cyc_step(1'b1);
         cyc_step(1'b0);
      end
      chk("gap1", {22'd0, gap_lo, gap_hi}, {22'd0, 5'd1, 5'd7});
      chk("pp_before_pipe", 32'(pipes_passed), 32'd0);

      cyc_step(1'b1);
      cyc_step(1'b0);
      chk("edge_col", 32'(col), 32'd3);
      cyc_step(1'b1);
      cyc_step(1'b0);
      chk("body_col", {22'd0, col, pipes_passed}, {22'd0, 2'b01, 8'd1});
      cyc_step(1'b1);
      cyc_step(1'b0);
      chk("empty_after_pipe", 32'(col), 32'd0);

      // Through the third draw (step 28) and third pipe (step 30)
      for (int i = 12; i <= 30; i++) cyc_step(1'b1);
      cyc_step(1'b0);
      chk("gap3", {14'd0, gap_lo, gap_hi, pipes_passed}, {14'd0, 5'd9, 5'd15, 8'd3});

      // Back-to-back steps in GAP, then into PIPE
      for (int i = 31; i <= 35; i++) cyc_step(1'b1);
      cyc_step(1'b0);
      for (int i = 36; i <= 39; i++) cyc_step(1'b1);

      // Asynchronous reset while col_valid is pending in PIPE
      @(posedge clk);
      #2;
      reset = 1'b1;
      q.delete();
      m_active = 1'b0;
      #1;
      chk_idle("async_reset");
      @(negedge clk);
      step = 1'b0;
      reset = 1'b0;
      m_reload();
      @(negedge clk);
      m_active = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc_step(1'b1);
         cyc_step(1'b0);
      end
      chk("rerun_gap1", {14'd0, gap_lo, gap_hi, pipes_passed}, {14'd0, 5'd1, 5'd7, 8'd0});

      // Long continuous run: ramp floor and pipes_passed saturation
      for (int i = 0; i < 2700; i++) cyc_step(1'b1);
      cyc_step(1'b0);
      chk("pp_saturated", 32'(pipes_passed), 32'd255);

      // Random stepping with rare run drops
      drop_run();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) drop_run();
         else cyc_step($urandom_range(0, 99) < 60);
      end
      repeat (3) cyc_step(1'b0);
      chk("drain", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
